// File: rtl/wb_grf_pkg.sv
// wb_grf_pkg: shared instruction-bus bit indices, reset constants and trace payload type
package wb_grf_pkg;
   localparam int INSTR_W = 28;
   localparam int NREG = 32;
   localparam logic [31:0] PC_RESET = 32'h0000_3000;
   localparam logic [4:0] ZERO_REG = 5'd0;
   localparam int I_CAL_R = 27;
   localparam int I_LUI = 26;
   localparam int I_LW = 25;
   localparam int I_LH = 24;
   localparam int I_LB = 23;
   localparam int I_SW = 22;
   localparam int I_SH = 21;
   localparam int I_SB = 20;
   localparam int I_BEQ = 19;
   localparam int I_BNE = 18;
   localparam int I_JAL = 17;
   localparam int I_JR = 16;
   localparam int I_JALR = 15;
   localparam int I_MULT = 14;
   localparam int I_DIV = 13;
   localparam int I_MFHI = 12;
   localparam int I_NOP = 11;
   localparam int I_MFLO = 10;
   localparam int I_MTHI = 9;
   localparam int I_MTLO = 8;
   localparam int I_ADDI = 7;
   localparam int I_ANDI = 6;
   localparam int I_SLTI = 5;
   localparam int I_SLTIU = 4;
   localparam int I_LHU = 3;
   localparam int I_LBU = 2;
   localparam int I_ORI = 1;
   localparam int I_XORI = 0;
   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  a3;
      logic [31:0] data;
   } trace_t;
endpackage

// File: rtl/wb_grf_if.sv
// wb_grf_if: M/W pipeline bundle, decode read ports and retire/trace outputs
interface wb_grf_if #(parameter int INSTR_W = wb_grf_pkg::INSTR_W);
   logic [4:0]         W_a3;
   logic               W_grf_en;
   logic [31:0]        W_vin;
   logic [31:0]        W_pc;
   logic [INSTR_W-1:0] W_instrbus;
   logic [4:0]         D_a1;
   logic [4:0]         D_a2;
   logic [31:0]        D_rd1;
   logic [31:0]        D_rd2;
   logic [31:0]        retire_cnt;
   logic               trace_valid;
   logic [31:0]        trace_pc;
   logic [4:0]         trace_a3;
   logic [31:0]        trace_data;
   modport master (
      output W_a3, W_grf_en, W_vin, W_pc, W_instrbus, D_a1, D_a2,
      input  D_rd1, D_rd2, retire_cnt, trace_valid, trace_pc, trace_a3, trace_data
   );
   modport slave (
      input  W_a3, W_grf_en, W_vin, W_pc, W_instrbus, D_a1, D_a2,
      output D_rd1, D_rd2, retire_cnt, trace_valid, trace_pc, trace_a3, trace_data
   );
endinterface

// File: rtl/wb_grf_grf_array.sv
// grf_array: register storage, one synchronous write port, two combinational reads, $0 reads zero
module grf_array #(
   parameter int NREG = wb_grf_pkg::NREG
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   import wb_grf_pkg::*;
   logic [31:0] regs [NREG];
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && wa != ZERO_REG) begin
         regs[wa] <= wd;
      end
   end
   assign rd1 = (ra1 == ZERO_REG) ? '0 : regs[ra1];
   assign rd2 = (ra2 == ZERO_REG) ? '0 : regs[ra2];
endmodule

// File: rtl/wb_grf.sv
// wb_grf: write-back stage register file with W->D bypass, retire counter and registered trace
module wb_grf #(
   parameter int          NREG     = wb_grf_pkg::NREG,
   parameter logic [31:0] PC_RESET = wb_grf_pkg::PC_RESET,
   parameter int          INSTR_W  = wb_grf_pkg::INSTR_W,
   parameter int          NOP_BIT  = wb_grf_pkg::I_NOP
) (
   input logic    clk,
   input logic    reset,
   wb_grf_if.slave bus
);
   import wb_grf_pkg::*;
   logic        we_eff;
   logic        retire;
   logic [31:0] rf1, rf2, cnt;
   logic        tv;
   trace_t      tr;
   assign we_eff = bus.W_grf_en && bus.W_a3 != ZERO_REG && !reset;
   assign retire = !reset && (|bus.W_instrbus) && !bus.W_instrbus[NOP_BIT];
   grf_array #(.NREG(NREG)) u_rf (
      .clk   (clk),
      .reset (reset),
      .we    (we_eff),
      .wa    (bus.W_a3),
      .wd    (bus.W_vin),
      .ra1   (bus.D_a1),
      .ra2   (bus.D_a2),
      .rd1   (rf1),
      .rd2   (rf2)
   );
   assign bus.D_rd1 = (bus.D_a1 == ZERO_REG) ? '0 :
                      (bus.W_grf_en && bus.W_a3 == bus.D_a1) ? bus.W_vin : rf1;
   assign bus.D_rd2 = (bus.D_a2 == ZERO_REG) ? '0 :
                      (bus.W_grf_en && bus.W_a3 == bus.D_a2) ? bus.W_vin : rf2;
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         tv  <= 1'b0;
         tr  <= '{pc: PC_RESET, a3: ZERO_REG, data: '0};
      end else begin
         if (retire) cnt <= cnt + 32'd1;
         tv <= we_eff;
         if (we_eff) tr <= '{pc: bus.W_pc, a3: bus.W_a3, data: bus.W_vin};
      end
   end
   assign bus.retire_cnt  = cnt;
   assign bus.trace_valid = tv;
   assign bus.trace_pc    = tr.pc;
   assign bus.trace_a3    = tr.a3;
   assign bus.trace_data  = tr.data;
endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Write-back end of the M/W pipeline interface: consumes the W_* pipeline-register bundle produced by the memory stage and commits results into the 32x32 general register file.
- Serves the decode-stage read ports, with internal W->D bypass (write-first).
- Keeps a retired-instruction counter and emits a registered one-cycle write-back trace for the bench and debug.

Parameters:
- NREG, 32, number of architectural registers; index 0 hardwired to zero.
- PC_RESET, 32'h0000_3000, reset value of trace_pc.
- INSTR_W, 28, width of the instruction one-hot bus.
- NOP_BIT, 11, bit index of the nop flag within W_instrbus.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- W_a3  in  5  destination register index from M/W register.
- W_grf_en  in  1  register write enable from M/W register.
- W_vin  in  32  write-back data (load data or ALU/link result already selected upstream).
- W_pc  in  32  PC of instruction in W.
- W_instrbus  in  INSTR_W  one-hot instruction class bus; all-zero = bubble.
- D_a1  in  5  decode read address 1.
- D_a2  in  5  decode read address 2.
- D_rd1  out  32  read data 1, combinational.
- D_rd2  out  32  read data 2, combinational.
- retire_cnt  out  32  count of retired non-bubble instructions.
- trace_valid  out  1  registered pulse: a register write committed last cycle.
- trace_pc  out  32  PC of the traced write.
- trace_a3  out  5  register index of the traced write.
- trace_data  out  32  value of the traced write.

Behaviour:
- Effective write: we_eff = W_grf_en && (W_a3 != 0) && !reset.
- On clk edge with we_eff, regs[W_a3] <= W_vin.
- reset: all regs <= 0, retire_cnt <= 0, trace_valid <= 0, trace_pc <= PC_RESET, trace_a3 <= 0, trace_data <= 0.
  - Reset wins over any simultaneous write or retire.
  - Mid-operation reset discards the in-flight W instruction: no write, no count, no trace.
- Reads, evaluated per port (a1/a2 independently):
  - Address 0 -> 32'h0, always.
  - Else if W_grf_en && W_a3 == address -> W_vin (bypass, same-cycle write visible).
  - Else regs[address].
- Bypass ignores reset. Irrelevant in practice: D-stage data is discarded during reset.
- Retire: retire = !reset && (W_instrbus != 0) && !W_instrbus[NOP_BIT]; retire_cnt += 1 on retire.
  - Counts stores and branches too (no write required).
  - 32-bit wrap: 32'hFFFF_FFFF -> 0 with no flag.
- Trace: registered, latency 1 cycle after the committing edge.
  - trace_valid <= we_eff.
  - When we_eff: trace_pc <= W_pc, trace_a3 <= W_a3, trace_data <= W_vin.
  - When not we_eff, payload holds its previous value; only trace_valid drops.
- Writes to $0: no state change, no trace, but counted as retired if not a bubble/nop.
- Back-to-back writes to the same register: last writer wins; each write produces its own trace pulse.
- No handshake or stall input: W stage never stalls. Upstream freezes W by presenting W_grf_en=0 and a bubble.

Decomposition:
- Shared package holds:
  - instruction-bus bit-index constants (cal_r=27 ... nop=11 ... xori=0) and INSTR_W;
  - PC_RESET;
  - register index constant ZERO_REG=0.
- One natural sub-module: grf_array. It holds the storage with one synchronous write port, two combinational read ports and the $0 rule.
- wb_grf wraps it with bypass, retire counter and trace register.

Test Plan:
- Reset check: reset=1 for 2 cycles with W_grf_en=1, W_a3=5, W_vin=32'hDEAD -> after release D_rd1(a1=5)=0, retire_cnt=0, trace_valid=0, trace_pc=32'h3000.
- Write/read: W_a3=8, W_vin=32'h1234_5678, W_grf_en=1, W_instrbus=ori one-hot, W_pc=32'h3004. Response:
  - same cycle, D_a1=8 reads 32'h1234_5678 via bypass;
  - next cycle, trace_valid=1, trace_pc=32'h3004, trace_a3=8, trace_data=32'h1234_5678;
  - retire_cnt=1.
- $0 protection: write 32'hFFFF_FFFF to a3=0 with lw one-hot -> D_rd1(a1=0)=0, trace_valid stays 0, retire_cnt increments by 1.
- Bubble/nop: W_instrbus=0, then only nop bit set, W_grf_en=0 -> retire_cnt unchanged, no trace, registers unchanged.
- Same-register burst: writes to r3 of 1, 2, 3 on consecutive cycles -> three trace pulses with data 1, 2, 3; D_rd2(a2=3)=3 afterwards.
- Counter wrap: retire_cnt forced/preloaded by running to 32'hFFFF_FFFF, one more sw retire -> retire_cnt=0. Reset asserted during a write to r9 -> r9 stays 0, no trace.
